// File: rtl/altair_pkg.sv
// Shared types and defaults for the Altair reset path.
// Holds the sequencer state encoding and the default pulse/settle lengths.
package altair_pkg;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_ASSERT,
    RS_SETTLE,
    RS_DONE
  } rs_state_t;

  localparam int DEFAULT_PULSE_LEN  = 16;
  localparam int DEFAULT_SETTLE_LEN = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser per bit followed by a history flop.
// rise is high for one cycle when a synchronised level goes from 0 to 1.
module sync_edge #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      hist <= '0;
    end else begin
      stage[0] <= async_in;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      hist <= stage[STAGES-1];
    end
  end

  assign sync_out = stage[STAGES-1];
  assign rise     = sync_out & ~hist;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronised, masked trigger edges start a reset pulse,
// a settle interval and a done strobe. Optional cause register: RESET_SEQ_CAUSE_EN.
module reset_sequencer
  import altair_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int LOAD_IDX    = 0,
  parameter int PULSE_LEN   = DEFAULT_PULSE_LEN,
  parameter int SETTLE_LEN  = DEFAULT_SETTLE_LEN,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] trig_in,
  input  logic [NUM_SRC-1:0] trig_mask,
  input  logic [SEL_W-1:0]   sel_in,
  output logic [SEL_W-1:0]   sel_out,
  output logic               machine_reset,
  output logic               busy,
  output logic               done
`ifdef RESET_SEQ_CAUSE_EN
  ,
  input  logic               cause_clr,
  output logic [NUM_SRC-1:0] cause
`endif
);

  localparam int CNT_W = $clog2(max_int(PULSE_LEN, SETTLE_LEN) + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE_LEN > 0) ? CNT_W'(SETTLE_LEN - 1) : '0;

  rs_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [NUM_SRC-1:0] sync_lvl_unused;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] edge_vec;
  logic any_edge;

  sync_edge #(
    .WIDTH  (NUM_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (trig_in),
    .sync_out (sync_lvl_unused),
    .rise     (rise)
  );

  assign edge_vec = rise & ~trig_mask;
  assign any_edge = |edge_vec;

  // A fresh edge always restarts the pulse, taking priority over completion.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      RS_IDLE: begin
        if (any_edge) begin
          state_d = RS_ASSERT;
          cnt_d   = '0;
        end
      end
      RS_ASSERT: begin
        if (any_edge) begin
          cnt_d = '0;
        end else if (cnt == PULSE_LAST) begin
          state_d = (SETTLE_LEN == 0) ? RS_DONE : RS_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RS_SETTLE: begin
        if (any_edge) begin
          state_d = RS_ASSERT;
          cnt_d   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_d = RS_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RS_DONE: begin
        state_d = any_edge ? RS_ASSERT : RS_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = RS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RS_ASSERT;
      cnt           <= '0;
      machine_reset <= 1'b1;
      busy          <= 1'b1;
      done          <= 1'b0;
      sel_out       <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      machine_reset <= (state_d == RS_ASSERT);
      busy          <= (state_d == RS_ASSERT) || (state_d == RS_SETTLE);
      done          <= (state_d == RS_DONE);
      if (edge_vec[LOAD_IDX]) sel_out <= sel_in;
    end
  end

`ifdef RESET_SEQ_CAUSE_EN
  // New edges survive a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause <= '0;
    end else begin
      cause <= (cause_clr ? '0 : cause) | edge_vec;
    end
  end
`endif

endmodule
